// File: rtl/mips_mc_control.sv
// Multi-cycle control unit for a MIPS datapath. It decodes the instruction,
// sequences a request/acknowledge data-memory access, raises a sticky trap on
// illegal instructions or a memory timeout, and counts retired instructions.
module mips_mc_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instruction,
    input  logic             Zero,
    input  logic             mem_ack,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             ALUSrc,
    output logic             PCSrc,
    output logic             Jump,
    output logic [3:0]       ALUCtrl,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             mem_req,
    output logic             pc_en,
    output logic             trap,
    output logic [1:0]       trap_code,
    output logic [CNT_W-1:0] instret
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_TIMEOUT = 2'b10;

    // Counter value seen in the last permitted wait cycle.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       tcnt_q, tcnt_d;
    logic [1:0]       trap_code_q, trap_code_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [5:0] opcode, funct;
    logic       unused_fields;
    assign opcode        = Instruction[31:26];
    assign funct         = Instruction[5:0];
    assign unused_fields = ^Instruction[25:6];

    logic       dec_legal, dec_lw, dec_sw, dec_reg_dst, dec_reg_write, dec_alu_src;
    logic       dec_beq, dec_bne, dec_jump;
    logic [3:0] dec_alu_ctrl;

    // Pure instruction decode, independent of sequencing state.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; that is what keeps this block free of latches.
        dec_legal     = 1'b1;
        dec_lw        = 1'b0;
        dec_sw        = 1'b0;
        dec_reg_dst   = 1'b0;
        dec_reg_write = 1'b0;
        dec_alu_src   = 1'b0;
        dec_beq       = 1'b0;
        dec_bne       = 1'b0;
        dec_jump      = 1'b0;
        dec_alu_ctrl  = ALU_ADD;
        unique case (opcode)
            6'b000000: begin
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                case (funct)
                    6'b100000: dec_alu_ctrl = ALU_ADD;
                    6'b100010: dec_alu_ctrl = ALU_SUB;
                    6'b100100: dec_alu_ctrl = ALU_AND;
                    6'b100101: dec_alu_ctrl = ALU_OR;
                    6'b100111: dec_alu_ctrl = ALU_NOR;
                    6'b101010: dec_alu_ctrl = ALU_SLT;
                    6'b000000: dec_alu_ctrl = ALU_SLL;
                    6'b000010: dec_alu_ctrl = ALU_SRL;
                    default:   dec_legal    = 1'b0;
                endcase
            end
            6'b100011: begin dec_lw = 1'b1; dec_alu_src = 1'b1; end
            6'b101011: begin dec_sw = 1'b1; dec_alu_src = 1'b1; end
            6'b000100: begin dec_beq = 1'b1; dec_alu_ctrl = ALU_SUB; end
            6'b000101: begin dec_bne = 1'b1; dec_alu_ctrl = ALU_SUB; end
            6'b001000: begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_ADD; end
            6'b001100: begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_AND; end
            6'b001101: begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_OR;  end
            6'b001010: begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_alu_ctrl = ALU_SLT; end
            6'b000010: dec_jump = 1'b1;
            default:   dec_legal = 1'b0;
        endcase
    end

    // Sequencing: next state plus every datapath control for this cycle.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        trap_code_d = trap_code_q;
        instret_d   = instret_q;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrc      = 1'b0;
        PCSrc       = 1'b0;
        Jump        = 1'b0;
        ALUCtrl     = ALU_ADD;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        mem_req     = 1'b0;
        pc_en       = 1'b0;
        trap        = 1'b0;
        trap_code   = trap_code_q;
        unique case (state_q)
            ST_RUN: begin
                if (!dec_legal) begin
                    state_d     = ST_TRAP;
                    trap_code_d = TC_ILLEGAL;
                end else if (dec_lw || dec_sw) begin
                    ALUSrc   = 1'b1;
                    ALUCtrl  = ALU_ADD;
                    MemRead  = dec_lw;
                    MemWrite = dec_sw;
                    mem_req  = 1'b1;
                    state_d  = ST_MEM_WAIT;
                    tcnt_d   = '0;
                end else begin
                    RegDst    = dec_reg_dst;
                    RegWrite  = dec_reg_write;
                    ALUSrc    = dec_alu_src;
                    ALUCtrl   = dec_alu_ctrl;
                    PCSrc     = (dec_beq & Zero) | (dec_bne & ~Zero);
                    Jump      = dec_jump;
                    pc_en     = 1'b1;
                    instret_d = instret_q + 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                ALUSrc   = 1'b1;
                ALUCtrl  = ALU_ADD;
                MemRead  = dec_lw;
                MemWrite = dec_sw;
                mem_req  = 1'b1;
                // An ack in the expiry cycle still completes the access.
                if (mem_ack) begin
                    pc_en     = 1'b1;
                    RegWrite  = dec_lw;
                    MemtoReg  = dec_lw;
                    instret_d = instret_q + 1'b1;
                    state_d   = ST_RUN;
                    tcnt_d    = '0;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                    if (tcnt_q == TMO_LAST) begin
                        state_d     = ST_TRAP;
                        trap_code_d = TC_TIMEOUT;
                    end
                end
            end
            default: begin
                trap = 1'b1;
            end
        endcase
        // Reset cycle: nothing may write, request or advance the PC.
        if (reset) begin
            RegWrite  = 1'b0;
            MemtoReg  = 1'b0;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            mem_req   = 1'b0;
            pc_en     = 1'b0;
            trap      = 1'b0;
            trap_code = TC_NONE;
        end
    end

    assign instret = instret_q;

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= ST_RUN;
            tcnt_q      <= '0;
            trap_code_q <= TC_NONE;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            trap_code_q <= trap_code_d;
            instret_q   <= instret_d;
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: decode vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_mips_mc_control;

    localparam int TMO = 15;
    localparam int CW  = 4;   // narrow counter so wrap-around is reachable

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, Zero, mem_ack;
    logic [31:0]   Instruction;
    logic          RegDst, RegWrite, MemtoReg, ALUSrc, PCSrc, Jump;
    logic [3:0]    ALUCtrl;
    logic          MemRead, MemWrite, mem_req, pc_en, trap;
    logic [1:0]    trap_code;
    logic [CW-1:0] instret;

    mips_mc_control #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .Instruction(Instruction), .Zero(Zero),
        .mem_ack(mem_ack), .RegDst(RegDst), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .PCSrc(PCSrc), .Jump(Jump),
        .ALUCtrl(ALUCtrl), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_req(mem_req), .pc_en(pc_en), .trap(trap), .trap_code(trap_code),
        .instret(instret)
    );

    typedef struct packed {
        logic       reg_dst, reg_write, memtoreg, alu_src, pc_src, jump;
        logic [3:0] alu_ctrl;
        logic       mem_read, mem_write, mem_req, pc_en, trap;
        logic [1:0] trap_code;
    } ctl_t;

    localparam logic [16:0] M_ALL = 17'h1FFFF;
    localparam logic [16:0] M_EN  = 17'h0807F;  // write enables, req, pc_en, trap
    localparam logic [16:0] M_RST = 17'h08078;  // controls forced low in reset
    localparam logic [16:0] M_BR  = 17'h0FFFF;  // RegDst irrelevant
    localparam logic [16:0] M_J   = 17'h0F87F;  // RegDst and ALU irrelevant

    localparam logic [31:0] I_ADD = 32'h012A4020;
    localparam logic [31:0] I_LW  = 32'h8D280004;
    localparam logic [31:0] I_SW  = 32'hAD280000;
    localparam logic [31:0] I_BAD = 32'hFC000000;
    localparam logic [31:0] I_BADF = 32'h0000003F;

    ctl_t act;
    assign act = {RegDst, RegWrite, MemtoReg, ALUSrc, PCSrc, Jump, ALUCtrl,
                  MemRead, MemWrite, mem_req, pc_en, trap, trap_code};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    ctl_t last_out;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic ctl_t mk(bit rd, bit rw, bit as, bit ps, bit jp, logic [3:0] alu);
        ctl_t c = '0;
        c.reg_dst = rd; c.reg_write = rw; c.alu_src = as;
        c.pc_src = ps; c.jump = jp; c.alu_ctrl = alu; c.pc_en = 1'b1;
        return c;
    endfunction

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit          legal;
        bit          mem;
        bit          lw;
        ctl_t        run_ctl;
        logic [16:0] run_mask;
    } dec_t;

    function automatic dec_t decode(logic [31:0] ins, logic z);
        dec_t d;
        d.legal = 1'b1; d.mem = 1'b0; d.lw = 1'b0; d.run_mask = M_ALL;
        d.run_ctl = '0;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: d.run_ctl = mk(1, 1, 0, 0, 0, 4'd2);
                6'h22: d.run_ctl = mk(1, 1, 0, 0, 0, 4'd6);
                6'h24: d.run_ctl = mk(1, 1, 0, 0, 0, 4'd0);
                6'h25: d.run_ctl = mk(1, 1, 0, 0, 0, 4'd1);
                6'h27: d.run_ctl = mk(1, 1, 0, 0, 0, 4'd12);
                6'h2A: d.run_ctl = mk(1, 1, 0, 0, 0, 4'd7);
                6'h00: d.run_ctl = mk(1, 1, 0, 0, 0, 4'd8);
                6'h02: d.run_ctl = mk(1, 1, 0, 0, 0, 4'd9);
                default: d.legal = 1'b0;
            endcase
            6'h23: begin d.mem = 1'b1; d.lw = 1'b1; end
            6'h2B: d.mem = 1'b1;
            6'h04: begin d.run_ctl = mk(0, 0, 0, z, 0, 4'd6);  d.run_mask = M_BR; end
            6'h05: begin d.run_ctl = mk(0, 0, 0, ~z, 0, 4'd6); d.run_mask = M_BR; end
            6'h08: d.run_ctl = mk(0, 1, 1, 0, 0, 4'd2);
            6'h0C: d.run_ctl = mk(0, 1, 1, 0, 0, 4'd0);
            6'h0D: d.run_ctl = mk(0, 1, 1, 0, 0, 4'd1);
            6'h0A: d.run_ctl = mk(0, 1, 1, 0, 0, 4'd7);
            6'h02: begin d.run_ctl = mk(0, 0, 0, 0, 1, 4'd0); d.run_mask = M_J; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    // mode: 0 executing, 1 waiting on memory, 2 trapped
    int m_mode = 0, m_waits = 0, m_ret = 0, m_code = 0;
    int n_mode, n_waits, n_ret, n_code;

    task automatic model_step(input logic rst, input logic [31:0] ins, input logic z,
                              input logic ack, output ctl_t e, output ctl_t m);
        dec_t d = decode(ins, z);
        e = '0; m = M_ALL;
        n_mode = m_mode; n_waits = m_waits; n_ret = m_ret; n_code = m_code;
        if (rst) begin
            m = M_RST;
            n_mode = 0; n_waits = 0; n_ret = 0; n_code = 0;
        end else if (m_mode == 2) begin
            m = M_EN;
            e.trap = 1'b1;
            e.trap_code = 2'(m_code);
        end else if (m_mode == 0 && !d.legal) begin
            m = M_EN;
            n_mode = 2; n_code = 1;
        end else if (m_mode == 0 && !d.mem) begin
            e = d.run_ctl; m = d.run_mask;
            n_ret = (m_ret + 1) % (1 << CW);
        end else begin
            if (!d.lw) m = M_BR;
            e.alu_src = 1'b1; e.alu_ctrl = 4'd2; e.mem_req = 1'b1;
            e.mem_read = d.lw; e.mem_write = ~d.lw;
            if (m_mode == 0) begin
                n_mode = 1; n_waits = 0;
            end else if (ack) begin
                e.pc_en = 1'b1; e.reg_write = d.lw; e.memtoreg = d.lw;
                n_ret = (m_ret + 1) % (1 << CW);
                n_mode = 0;
            end else begin
                n_waits = m_waits + 1;
                if (n_waits == TMO) begin n_mode = 2; n_code = 2; end
            end
        end
    endtask

    // One clock: apply inputs, compare at the falling edge, advance the model.
    task automatic drive(input logic rst, input logic [31:0] ins, input logic z, input logic ack);
        ctl_t e, m;
        reset = rst; Instruction = ins; Zero = z; mem_ack = ack;
        @(negedge clk);
        model_step(rst, ins, z, ack, e, m);
        last_out = act;
        check($sformatf("ctl c%0d", cyc), 32'(act & m), 32'(e & m));
        if (!rst) check($sformatf("instret c%0d", cyc), 32'(instret), 32'(m_ret));
        @(posedge clk); #1;
        m_mode = n_mode; m_waits = n_waits; m_ret = n_ret; m_code = n_code;
        cyc++;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic        z;
        ctl_t        exp;
        logic [16:0] mask;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [5:0] ops[14] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
                                6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02, 6'h3F, 6'h23};
        logic [5:0] fns[9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h3F};
        r[31:26] = ops[$urandom_range(0, 13)];
        if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(0, 8)];
        return r;
    endfunction

    logic [3:0] rq, pe, rw, mr;
    logic [31:0] cur;

    initial begin
        reset = 1'b1; Instruction = '0; Zero = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;

        // ---- decode table: one execution cycle after a reset ----
        vt.push_back('{32'h012A4020, 1'b0, mk(1, 1, 0, 0, 0, 4'b0010), M_ALL});
        vt.push_back('{32'h012A4022, 1'b0, mk(1, 1, 0, 0, 0, 4'b0110), M_ALL});
        vt.push_back('{32'h012A4024, 1'b0, mk(1, 1, 0, 0, 0, 4'b0000), M_ALL});
        vt.push_back('{32'h012A4025, 1'b0, mk(1, 1, 0, 0, 0, 4'b0001), M_ALL});
        vt.push_back('{32'h012A4027, 1'b0, mk(1, 1, 0, 0, 0, 4'b1100), M_ALL});
        vt.push_back('{32'h012A402A, 1'b0, mk(1, 1, 0, 0, 0, 4'b0111), M_ALL});
        vt.push_back('{32'h00094080, 1'b0, mk(1, 1, 0, 0, 0, 4'b1000), M_ALL});
        vt.push_back('{32'h00094082, 1'b0, mk(1, 1, 0, 0, 0, 4'b1001), M_ALL});
        vt.push_back('{32'h11090004, 1'b1, mk(0, 0, 0, 1, 0, 4'b0110), M_BR});
        vt.push_back('{32'h11090004, 1'b0, mk(0, 0, 0, 0, 0, 4'b0110), M_BR});
        vt.push_back('{32'h15090004, 1'b0, mk(0, 0, 0, 1, 0, 4'b0110), M_BR});
        vt.push_back('{32'h15090004, 1'b1, mk(0, 0, 0, 0, 0, 4'b0110), M_BR});
        vt.push_back('{32'h21280005, 1'b0, mk(0, 1, 1, 0, 0, 4'b0010), M_ALL});
        vt.push_back('{32'h31280005, 1'b0, mk(0, 1, 1, 0, 0, 4'b0000), M_ALL});
        vt.push_back('{32'h35280005, 1'b0, mk(0, 1, 1, 0, 0, 4'b0001), M_ALL});
        vt.push_back('{32'h29280005, 1'b0, mk(0, 1, 1, 0, 0, 4'b0111), M_ALL});
        vt.push_back('{32'h08000010, 1'b0, mk(0, 0, 0, 0, 1, 4'b0000), M_J});
        vt.push_back('{I_BAD,        1'b0, ctl_t'('0),                 M_EN});
        vt.push_back('{I_BADF,       1'b0, ctl_t'('0),                 M_EN});
        foreach (vt[i]) begin
            drive(1'b1, '0, 1'b0, 1'b0);
            drive(1'b0, vt[i].ins, vt[i].z, 1'b0);
            check($sformatf("vec%0d %h", i, vt[i].ins),
                  32'(last_out & vt[i].mask), 32'(vt[i].exp & vt[i].mask));
        end

        // ---- three adds retire three instructions ----
        drive(1'b1, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, I_ADD, 1'b0, 1'b0);
        check("add3 instret", 32'(instret), 32'd3);

        // ---- lw acknowledged on the third wait cycle ----
        drive(1'b1, '0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, I_LW, 1'b0, k == 3);
            rq[k] = last_out.mem_req; pe[k] = last_out.pc_en;
            rw[k] = last_out.reg_write; mr[k] = last_out.memtoreg;
        end
        check("lw mem_req", 32'(rq), 32'b1111);
        check("lw pc_en", 32'(pe), 32'b1000);
        check("lw RegWrite", 32'(rw), 32'b1000);
        check("lw MemtoReg", 32'(mr), 32'b1000);
        check("lw instret", 32'(instret), 32'd1);

        // ---- sw never acknowledged: timeout trap ----
        drive(1'b1, '0, 1'b0, 1'b0);
        drive(1'b0, I_SW, 1'b0, 1'b0);
        rq[0] = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            drive(1'b0, I_SW, 1'b0, 1'b0);
            rq[0] = rq[0] | last_out.trap;
        end
        check("sw trap early", 32'(rq[0]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, I_SW, 1'b0, 1'b1);
            check("tmo trap", 32'({last_out.trap, last_out.trap_code, last_out.mem_req, last_out.pc_en}),
                  32'b11000);
        end
        drive(1'b1, '0, 1'b0, 1'b0);
        drive(1'b0, I_ADD, 1'b0, 1'b0);
        check("trap cleared", 32'(last_out.trap), 32'd0);

        // ---- ack in the very cycle the timeout would expire ----
        drive(1'b1, '0, 1'b0, 1'b0);
        drive(1'b0, I_SW, 1'b0, 1'b0);
        for (int k = 0; k < TMO - 1; k++) drive(1'b0, I_SW, 1'b0, 1'b0);
        drive(1'b0, I_SW, 1'b0, 1'b1);
        check("late ack pc_en", 32'(last_out.pc_en), 32'd1);
        drive(1'b0, I_ADD, 1'b0, 1'b0);
        check("late ack no trap", 32'(last_out.trap), 32'd0);

        // ---- illegal opcode and funct trap immediately ----
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, '0, 1'b0, 1'b0);
            drive(1'b0, (k == 0) ? I_BAD : I_BADF, 1'b0, 1'b0);
            drive(1'b0, I_ADD, 1'b0, 1'b0);
            check("illegal trap", 32'({last_out.trap, last_out.trap_code, last_out.reg_write,
                                       last_out.mem_write, last_out.pc_en}), 32'b101000);
        end

        // ---- reset in the middle of an lw wait ----
        drive(1'b1, '0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, I_LW, 1'b0, 1'b0);
        drive(1'b1, I_LW, 1'b0, 1'b1);
        check("rst mw", 32'({last_out.reg_write, last_out.mem_req, last_out.pc_en}), 32'b000);
        drive(1'b0, I_LW, 1'b0, 1'b1);
        check("ack in run", 32'({last_out.reg_write, last_out.mem_req, last_out.pc_en}), 32'b010);
        check("rst instret", 32'(instret), 32'd0);
        drive(1'b0, I_LW, 1'b0, 1'b1);
        check("lw after rst", 32'({last_out.reg_write, last_out.pc_en}), 32'b11);

        // ---- counter wrap ----
        drive(1'b1, '0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) drive(1'b0, I_ADD, 1'b0, 1'b0);
        check("instret wrap", 32'(instret), 32'(20 % (1 << CW)));

        // ---- randomized run against the model ----
        drive(1'b1, '0, 1'b0, 1'b0);
        cur = rand_instr();
        for (int k = 0; k < 1500; k++) begin
            if (m_mode != 1) cur = rand_instr();
            drive($urandom_range(0, 59) == 0, cur, 1'(($urandom)), $urandom_range(0, 5) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
